instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 127 ++++++++++++
 tb/tb_instr_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Purpose: boot loader that turns a byte stream (count header + little-endian words)
//          into instruction memory writes, holding the CPU off fetch until the load is done.
// Latency: one byte accepted per cycle in HDR/DATA, each word written the cycle after its
//          4th byte (one word per 5 cycles at full rate).
// Backpressure: in_ready is registered, high only in HDR and DATA; it drops for the write
//          cycle and in every idle/terminal state, so bytes offered then are not consumed.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           one-cycle pulse, begins a load from IDLE, DONE or ERR
//   in_valid/in_data/in_ready   byte stream handshake
//   mem_we/mem_addr/mem_wdata   instruction memory write port
//   busy, done, error, cpu_hold status (all registered)
module instr_loader #(
  parameter int unsigned SIZE          = 32,
  parameter int unsigned ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH:0]   mem_addr,
  output logic [31:0]              mem_wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     cpu_hold
);

  typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, DONE, ERR} state_t;

  localparam logic [ADDRESS_WIDTH:0] ADDR_ONE = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

  state_t     state;
  logic [7:0] word_cnt;    // N from the header
  logic [7:0] words_done;  // words written so far in this load
  logic [1:0] byte_idx;    // byte lane of the next data byte

  logic accept;
  logic hdr_bad;

  assign accept  = in_valid && in_ready;
  // A zero count or one larger than the memory can never be a valid program.
  assign hdr_bad = (in_data == 8'd0) || (32'(in_data) > SIZE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      word_cnt   <= 8'd0;
      words_done <= 8'd0;
      byte_idx   <= 2'd0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_hold   <= 1'b1;
    end else begin
      // The write strobe is only ever raised on entry to WRITE, so it lasts one cycle.
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= HDR;
            word_cnt   <= 8'd0;
            words_done <= 8'd0;
            byte_idx   <= 2'd0;
            mem_addr   <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_hold   <= 1'b1;
          end
        end
        HDR: begin
          if (accept) begin
            if (hdr_bad) begin
              state    <= ERR;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              error    <= 1'b1;
            end else begin
              word_cnt <= in_data;
              state    <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            mem_wdata[{byte_idx, 3'b000} +: 8] <= in_data;
            byte_idx <= byte_idx + 2'd1;  // wraps to lane 0 for the next word
            if (byte_idx == 2'd3) begin
              state    <= WRITE;
              in_ready <= 1'b0;
              mem_we   <= 1'b1;
            end
          end
        end
        WRITE: begin
          mem_addr   <= mem_addr + ADDR_ONE;
          words_done <= words_done + 8'd1;
          if (words_done + 8'd1 == word_cnt) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            state    <= DATA;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Purpose: randomized self-checking bench for instr_loader against a byte-stream model.
// Latency: n/a (bench).
// Backpressure: bytes are held on in_valid until the loader shows in_ready.
module tb_instr_loader;

  localparam int SIZE = 32;
  localparam int AW   = 5;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          start    = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data  = 8'd0;
  logic          in_ready;
  logic          mem_we;
  logic [AW:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          error;
  logic          cpu_hold;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Observed memory writes of the current load.
  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  // Optional fixed payload for directed loads; empty means random bytes.
  logic [7:0]  fixed_q[$];

  instr_loader #(.SIZE(SIZE), .ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst && mem_we) begin
      chk("ready_low_in_write", 64'(in_ready), 64'd0);
      chk("write_addr_in_range", 64'(int'(mem_addr) < SIZE), 64'd1);
      wr_addr.push_back(int'(mem_addr));
      wr_data.push_back(mem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_mem_we"},   64'(mem_we),   64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_wdata"},    64'(mem_wdata), 64'd0);
    chk({tag, "_busy"},     64'(busy),     64'd0);
    chk({tag, "_done"},     64'(done),     64'd0);
    chk({tag, "_error"},    64'(error),    64'd0);
    chk({tag, "_hold"},     64'(cpu_hold), 64'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy",  64'(busy),     64'd1);
    chk("start_ready", 64'(in_ready), 64'd1);
    chk("start_hold",  64'(cpu_hold), 64'd1);
    chk("start_flags", 64'({done, error}), 64'd0);
  endtask

  // Offer a byte after an idle gap and hold it until it is taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        chk("accept_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // One complete load: header n, 4n bytes if n is legal, then stray bytes.
  task automatic run_load(input int n, input int max_gap, input int start_at);
    logic [7:0] b[$];
    bit ok;
    int exp_n;
    ok    = (n >= 1) && (n <= SIZE);
    exp_n = ok ? n : 0;
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    pulse_start();
    send_byte(8'(n), int'($urandom_range(0, max_gap)));
    if (ok) begin
      for (int i = 0; i < 4 * n; i++) begin
        b.push_back((fixed_q.size() > i) ? fixed_q[i] : 8'($urandom));
        send_byte(b[i], int'($urandom_range(0, max_gap)));
        if (i == start_at) begin
          in_valid = 1'b0;
          start    = 1'b1;
          @(posedge clk); #1;
          start    = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("nwrites", 64'(wr_addr.size()), 64'(exp_n));
    for (int i = 0; i < wr_addr.size() && i < exp_n; i++) begin
      chk("waddr", 64'(wr_addr[i]), 64'(i));
      chk("wdata", 64'(wr_data[i]), 64'({b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]}));
      if (max_gap == 0 && start_at < 0 && i > 0)
        chk("throughput", 64'(wr_cyc[i] - wr_cyc[i-1]), 64'd5);
    end
    chk("end_done",  64'(done),     64'(ok));
    chk("end_error", 64'(error),    64'(!ok));
    chk("end_hold",  64'(cpu_hold), 64'(!ok));
    chk("end_busy",  64'(busy),     64'd0);
    chk("end_ready", 64'(in_ready), 64'd0);
    // Stray bytes after completion must change nothing.
    repeat (8) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("extra_nwrites", 64'(wr_addr.size()), 64'(exp_n));
    chk("extra_addr",    64'(mem_addr), 64'(exp_n));
    chk("extra_flags",   64'({done, error, busy}), 64'({ok, !ok, 1'b0}));
  endtask

  logic [7:0] dir_bytes [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

  initial begin
    // Asynchronous reset: values must appear before any clock edge.
    #1 rst = 1'b0;
    #1 check_reset_vals("rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h05;
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("idle_no_start_busy",  64'(busy),     64'd0);
    chk("idle_no_start_ready", 64'(in_ready), 64'd0);

    // Directed two-word program at full rate.
    for (int i = 0; i < 8; i++) fixed_q.push_back(dir_bytes[i]);
    run_load(2, 0, -1);
    if (wr_data.size() == 2) begin
      chk("dir_word0", 64'(wr_data[0]), 64'h0000_0013);
      chk("dir_word1", 64'(wr_data[1]), 64'hDEAD_BEEF);
    end else begin
      chk("dir_word_count", 64'(wr_data.size()), 64'd2);
    end
    fixed_q.delete();

    // Bad headers, back to back.
    run_load(0, 1, -1);
    run_load(SIZE + 1, 1, -1);

    // Full memory with random valid gaps.
    run_load(SIZE, 3, -1);

    // Start pulsed mid-word is ignored.
    run_load(2, 0, 5);

    // Reset in the middle of word 1 of a 3-word load.
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    pulse_start();
    send_byte(8'd3, 0);
    for (int i = 0; i < 7; i++) fixed_q.push_back(8'($urandom));
    for (int i = 0; i < 7; i++) send_byte(fixed_q[i], 1);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1 check_reset_vals("midrst");
    chk("midrst_nwrites", 64'(wr_addr.size()), 64'd1);
    if (wr_addr.size() >= 1)
      chk("midrst_word0", 64'(wr_data[0]),
          64'({fixed_q[3], fixed_q[2], fixed_q[1], fixed_q[0]}));
    fixed_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    in_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("postrst_busy",    64'(busy),     64'd0);
    chk("postrst_ready",   64'(in_ready), 64'd0);
    chk("postrst_nwrites", 64'(wr_addr.size()), 64'd1);
    run_load(2, 1, -1);

    // Random loads, including illegal counts.
    for (int t = 0; t < 5; t++)
      run_load(int'($urandom_range(0, SIZE + 4)), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 12)) - 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
